// File: rtl/filter_sched_pkg.sv
// ---------------------------------------------------------------------------
// sched_pkg
// Shared definitions for the filter_sched block: FSM state encoding, channel
// count and the channel index type used by the scheduler and its interface.
// ---------------------------------------------------------------------------
package sched_pkg;

  localparam int N_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    COMMIT = 3'd4
  } sched_state_t;

  // Index of the channel that follows ch (wraps 3 -> 0).
  function automatic ch_idx_t next_ch(input ch_idx_t ch);
    return ch + 2'd1;
  endfunction

endpackage

// File: rtl/filter_sched_if.sv
// ---------------------------------------------------------------------------
// filter_sched_if
// Handshake between the scheduler and the shared single-channel filter core.
//   core_start : one-cycle start pulse (scheduler -> core)
//   core_ch    : channel index selecting the core's state bank
//   core_in    : sample for core_ch, stable from start until result
//   core_done  : one-cycle result-valid pulse (core -> scheduler)
//   core_out   : result, valid while core_done is high
// master = scheduler side, slave = core side.
// ---------------------------------------------------------------------------
interface filter_sched_if #(parameter int W = 16);
  import sched_pkg::*;

  logic         core_start;
  ch_idx_t      core_ch;
  logic [W-1:0] core_in;
  logic         core_done;
  logic [W-1:0] core_out;

  modport master (
    output core_start,
    output core_ch,
    output core_in,
    input  core_done,
    input  core_out
  );

  modport slave (
    input  core_start,
    input  core_ch,
    input  core_in,
    output core_done,
    output core_out
  );

endinterface

// File: rtl/filter_sched_watchdog.sv
// ---------------------------------------------------------------------------
// sched_watchdog
// Per-channel wait counter. Cleared when a channel is issued, incremented
// while the scheduler waits, and flags terminal count at TIMEOUT-1.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : load zero (has priority over i_inc)
//   i_inc    : increment by one
//   o_tc     : count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module sched_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [15:0] TC_VAL = 16'(TIMEOUT - 1);

  logic [15:0] r_cnt;

  // Wait-cycle counter with clear priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (i_clr) begin
      r_cnt <= 16'd0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/filter_sched.sv
// ---------------------------------------------------------------------------
// filter_sched
// Time-multiplexes one shared filter core across four audio channels per
// sample period. On a rising sample_clk the four inputs and the enable mask
// are latched; each channel is either passed to the core (start, wait for
// done or watchdog expiry) or bypassed; all four results are then committed
// to the outputs in the same cycle.
//   clk, rst            : clock, synchronous active-high reset
//   sample_clk          : sample strobe (sync to clk), rising edge = new frame
//   sample_in0..3       : signed channel inputs
//   sample_out0..3      : signed channel outputs, updated only on commit
//   ch_enable           : 1 = route channel through core, 0 = bypass
//   core                : handshake to the shared filter core (master side)
//   frame_done          : one-cycle pulse with the output update
//   clear_flags         : clears overrun/timeout (a same-cycle set wins)
//   overrun             : sticky, sample edge arrived mid-frame
//   timeout             : sticky, a channel exceeded TIMEOUT wait cycles
// ---------------------------------------------------------------------------
module filter_sched
  import sched_pkg::*;
#(
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  input  logic [N_CH-1:0]     ch_enable,
  filter_sched_if.master      core,
  output logic                frame_done,
  input  logic                clear_flags,
  output logic                overrun,
  output logic                timeout
);

  sched_state_t              r_state;
  ch_idx_t                   r_ch;
  logic                      r_sc_q;
  logic [N_CH-1:0][W-1:0]    r_in;
  logic [N_CH-1:0]           r_en;
  logic [N_CH-1:0][W-1:0]    r_res;
  logic [N_CH-1:0][W-1:0]    r_out;
  logic                      r_core_start;
  ch_idx_t                   r_core_ch;
  logic [W-1:0]              r_core_in;
  logic                      r_frame_done;
  logic                      r_overrun;
  logic                      r_timeout;

  logic                      w_edge;
  ch_idx_t                   w_ch_nx;
  logic [W-1:0]              w_in_cur;
  logic                      w_en_cur;
  logic [W-1:0]              w_in_nx;
  logic                      w_en_nx;
  logic                      w_tc;
  logic                      w_wd_clr;
  logic                      w_wd_inc;
  logic                      w_to_set;
  logic                      w_ov_set;

  assign w_edge   = sample_clk & ~r_sc_q;
  assign w_ch_nx  = next_ch(r_ch);
  assign w_in_cur = r_in[r_ch];
  assign w_en_cur = r_en[r_ch];
  assign w_in_nx  = r_in[w_ch_nx];
  assign w_en_nx  = r_en[w_ch_nx];

  // Watchdog runs only while waiting on the core; done takes priority over
  // expiry, so a result on the last allowed cycle is still accepted.
  assign w_wd_clr = (r_state == ISSUE);
  assign w_wd_inc = (r_state == WAIT) & ~core.core_done & ~w_tc;
  assign w_to_set = (r_state == WAIT) & ~core.core_done & w_tc;
  assign w_ov_set = w_edge & (r_state != IDLE);

  sched_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_wd_clr),
    .i_inc(w_wd_inc),
    .o_tc (w_tc)
  );

  // Sticky status flags; a set event in the same cycle as clear_flags wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_ov_set) begin
        r_overrun <= 1'b1;
      end else if (clear_flags) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
      if (w_to_set) begin
        r_timeout <= 1'b1;
      end else if (clear_flags) begin
        r_timeout <= 1'b0;
      end else begin
        r_timeout <= r_timeout;
      end
    end
  end

  // Frame sequencer. core_start/core_ch/core_in are loaded on entry to
  // ISSUE so the start pulse coincides with the ISSUE cycle and the channel
  // and sample stay stable through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ch         <= 2'd0;
      r_sc_q       <= 1'b0;
      r_in         <= '0;
      r_en         <= '0;
      r_res        <= '0;
      r_out        <= '0;
      r_core_start <= 1'b0;
      r_core_ch    <= 2'd0;
      r_core_in    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_sc_q       <= sample_clk;
      r_core_start <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_in[0]      <= sample_in0;
            r_in[1]      <= sample_in1;
            r_in[2]      <= sample_in2;
            r_in[3]      <= sample_in3;
            r_en         <= ch_enable;
            r_ch         <= 2'd0;
            r_core_ch    <= 2'd0;
            r_core_in    <= sample_in0;
            r_core_start <= ch_enable[0];
            r_state      <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          if (w_en_cur) begin
            r_state <= WAIT;
          end else begin
            r_res[r_ch] <= w_in_cur;
            r_state     <= NEXT;
          end
        end
        WAIT: begin
          if (core.core_done) begin
            r_res[r_ch] <= core.core_out;
            r_state     <= NEXT;
          end else if (w_tc) begin
            r_res[r_ch] <= '0;
            r_state     <= NEXT;
          end else begin
            r_state <= WAIT;
          end
        end
        NEXT: begin
          if (r_ch == 2'd3) begin
            r_state <= COMMIT;
          end else begin
            r_ch         <= w_ch_nx;
            r_core_ch    <= w_ch_nx;
            r_core_in    <= w_in_nx;
            r_core_start <= w_en_nx;
            r_state      <= ISSUE;
          end
        end
        COMMIT: begin
          r_out        <= r_res;
          r_frame_done <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sample_out0     = r_out[0];
  assign sample_out1     = r_out[1];
  assign sample_out2     = r_out[2];
  assign sample_out3     = r_out[3];
  assign core.core_start = r_core_start;
  assign core.core_ch    = r_core_ch;
  assign core.core_in    = r_core_in;
  assign frame_done      = r_frame_done;
  assign overrun         = r_overrun;
  assign timeout         = r_timeout;

endmodule
